// File: rtl/bram_logger_pkg.sv
// rtl/bram_logger_pkg.sv - shared widths and log-word packing for the BRAM logger arbiter
package bram_logger_pkg;

  localparam int SRC_ID_BITW   = 8;
  localparam int MAX_DATA_BITW = 1016;
  localparam int MAX_LOG_BITW  = SRC_ID_BITW + MAX_DATA_BITW;

  // The logger stores whole 32-bit words, so {ID, payload} must fill them exactly.
  function automatic bit log_width_ok(int data_bitw);
    return ((data_bitw + SRC_ID_BITW) % 32) == 0;
  endfunction

  function automatic logic [MAX_LOG_BITW-1:0] pack_log_word(
    logic [SRC_ID_BITW-1:0]   id,
    logic [MAX_DATA_BITW-1:0] data,
    int                       data_bitw
  );
    return (MAX_LOG_BITW'(id) << data_bitw) | MAX_LOG_BITW'(data);
  endfunction

endpackage

// File: rtl/bram_logger_arbiter_rr.sv
// rtl/bram_logger_arbiter_rr.sv - combinational round-robin pick starting at an external pointer
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_BITW = 2
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [IDX_BITW-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic [IDX_BITW-1:0] o_gnt_idx,
  output logic                o_any
);

  always_comb begin
    int                  j;
    logic [IDX_BITW-1:0] w_idx;
    j         = 0;
    w_idx     = '0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      w_idx = IDX_BITW'(j);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/bram_logger_arbiter.sv
// rtl/bram_logger_arbiter.sv - shares one BRAM logger between NUM_SRC event sources
module bram_logger_arbiter
  import bram_logger_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int SRC_DATA_BITW = 24,
  parameter int DROP_CNT_BITW = 16
) (
  input  logic                               Clk_CI,
  input  logic                               Rst_RI,
  input  logic                               Enable_SI,
  input  logic [NUM_SRC-1:0]                 SrcEn_SI,
  input  logic [NUM_SRC-1:0]                 SrcTrigger_SI,
  input  logic [NUM_SRC*SRC_DATA_BITW-1:0]   SrcData_DI,
  input  logic                               ClearReq_SI,
  input  logic                               DropClr_SI,
  input  logic                               LogReady_SI,
  output logic                               LogTrigger_SO,
  output logic [SRC_ID_BITW+SRC_DATA_BITW-1:0] LogData_DO,
  output logic                               LogClear_SO,
  output logic [NUM_SRC-1:0]                 Pending_SO,
  output logic [NUM_SRC*DROP_CNT_BITW-1:0]   DropCnt_DO,
  output logic                               Overflow_SO
);

  localparam int LOG_BITW = SRC_ID_BITW + SRC_DATA_BITW;
  localparam int PTR_BITW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [DROP_CNT_BITW-1:0] CNT_MAX = '1;

  if (!log_width_ok(SRC_DATA_BITW)) begin : g_bad_width
    $error("SRC_DATA_BITW + SRC_ID_BITW must be a multiple of 32");
  end

  logic [NUM_SRC-1:0]       r_pend_vld;
  logic [SRC_DATA_BITW-1:0] r_pend_data [NUM_SRC];
  logic [PTR_BITW-1:0]      r_rr_ptr;
  logic                     r_clear_pend;
  logic [DROP_CNT_BITW-1:0] r_drop_cnt [NUM_SRC];
  logic                     r_overflow;
  logic                     r_log_trig;
  logic                     r_log_clear;
  logic [LOG_BITW-1:0]      r_log_data;

  logic [NUM_SRC-1:0]       w_arb_gnt;
  logic [NUM_SRC-1:0]       w_gnt;
  logic [NUM_SRC-1:0]       w_cap;
  logic [NUM_SRC-1:0]       w_load;
  logic [NUM_SRC-1:0]       w_drop;
  logic [PTR_BITW-1:0]      w_gnt_idx;
  logic                     w_arb_any;
  logic                     w_grant_ok;
  logic                     w_clear_fire;
  logic [SRC_DATA_BITW-1:0] w_gnt_data;

  rr_arbiter #(
    .NUM_REQ  (NUM_SRC),
    .IDX_BITW (PTR_BITW)
  ) u_rr (
    .i_req     (r_pend_vld),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_arb_any)
  );

  // A pending or arriving clear request freezes grants so no write can race the clear.
  assign w_grant_ok   = Enable_SI & LogReady_SI & ~r_clear_pend & ~ClearReq_SI & w_arb_any;
  assign w_gnt        = w_grant_ok ? w_arb_gnt : '0;
  assign w_cap        = Enable_SI ? (SrcTrigger_SI & SrcEn_SI) : '0;
  assign w_load       = w_cap & (~r_pend_vld | w_gnt);
  assign w_drop       = w_cap & r_pend_vld & ~w_gnt;
  assign w_clear_fire = r_clear_pend & ~r_log_trig;
  assign w_gnt_data   = r_pend_data[w_gnt_idx];

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_pend_vld <= '0;
    end else begin
      r_pend_vld <= w_load | (r_pend_vld & ~w_gnt);
    end
  end

  always_ff @(posedge Clk_CI) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_load[i]) r_pend_data[i] <= SrcData_DI[i*SRC_DATA_BITW +: SRC_DATA_BITW];
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_log_trig   <= 1'b0;
      r_log_data   <= '0;
      r_log_clear  <= 1'b0;
      r_clear_pend <= 1'b0;
      r_rr_ptr     <= '0;
    end else begin
      r_log_trig <= w_grant_ok;
      if (w_grant_ok) begin
        r_log_data <= LOG_BITW'(pack_log_word(SRC_ID_BITW'(w_gnt_idx),
                                              MAX_DATA_BITW'(w_gnt_data), SRC_DATA_BITW));
        r_rr_ptr   <= (w_gnt_idx == PTR_BITW'(NUM_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      r_log_clear  <= w_clear_fire;
      r_clear_pend <= w_clear_fire ? 1'b0 : (r_clear_pend | ClearReq_SI);
    end
  end

  // A drop in the same cycle as DropClr_SI is counted after the clear.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      for (int i = 0; i < NUM_SRC; i++) r_drop_cnt[i] <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_drop[i]) begin
          if (DropClr_SI) r_drop_cnt[i] <= DROP_CNT_BITW'(1);
          else if (r_drop_cnt[i] != CNT_MAX) r_drop_cnt[i] <= r_drop_cnt[i] + 1'b1;
        end else if (DropClr_SI) begin
          r_drop_cnt[i] <= '0;
        end
      end
      if (|w_drop) r_overflow <= 1'b1;
      else if (DropClr_SI) r_overflow <= 1'b0;
    end
  end

  assign LogTrigger_SO = r_log_trig;
  assign LogData_DO    = r_log_data;
  assign LogClear_SO   = r_log_clear;
  assign Pending_SO    = r_pend_vld;
  assign Overflow_SO   = r_overflow;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
    assign DropCnt_DO[i*DROP_CNT_BITW +: DROP_CNT_BITW] = r_drop_cnt[i];
  end

endmodule

// File: tb/tb_bram_logger_arbiter.sv
// tb/tb_bram_logger_arbiter.sv - self-checking bench for bram_logger_arbiter
module tb_bram_logger_arbiter;

  localparam int NS = 4;
  localparam int DW = 24;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en, creq, dclr, rdy;
  logic [NS-1:0]  sen, trig;
  logic [DW-1:0]  d [NS];
  logic [NS*DW-1:0] data_flat;

  logic           o_trig, o_clear, o_ov;
  logic [31:0]    o_data;
  logic [NS-1:0]  o_pend;
  logic [NS*CW-1:0] o_cnt;

  always_comb begin
    data_flat = '0;
    for (int i = 0; i < NS; i++) data_flat[i*DW +: DW] = d[i];
  end

  bram_logger_arbiter #(
    .NUM_SRC       (NS),
    .SRC_DATA_BITW (DW),
    .DROP_CNT_BITW (CW)
  ) dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .Enable_SI     (en),
    .SrcEn_SI      (sen),
    .SrcTrigger_SI (trig),
    .SrcData_DI    (data_flat),
    .ClearReq_SI   (creq),
    .DropClr_SI    (dclr),
    .LogReady_SI   (rdy),
    .LogTrigger_SO (o_trig),
    .LogData_DO    (o_data),
    .LogClear_SO   (o_clear),
    .Pending_SO    (o_pend),
    .DropCnt_DO    (o_cnt),
    .Overflow_SO   (o_ov)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries, pointer, counters as plain integers.
  bit [NS-1:0]  m_pend;
  logic [DW-1:0] m_data [NS];
  int           m_ptr;
  bit           m_cpend, m_trig, m_lclear, m_ov;
  logic [31:0]  m_ldata;
  int           m_cnt [NS];

  task automatic model_step();
    bit [NS-1:0] old_pend;
    int g;
    bit any_drop, drop_i;
    if (rst) begin
      m_pend = '0; m_ptr = 0; m_cpend = 0; m_trig = 0; m_lclear = 0; m_ov = 0; m_ldata = '0;
      for (int i = 0; i < NS; i++) m_cnt[i] = 0;
      return;
    end
    old_pend = m_pend;
    g = -1;
    if (en && rdy && !m_cpend && !creq)
      for (int k = 0; k < NS; k++)
        if (g < 0 && old_pend[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
    if (m_cpend && !m_trig) begin
      m_lclear = 1; m_cpend = 0;
    end else begin
      m_lclear = 0; m_cpend = m_cpend | creq;
    end
    m_trig = (g >= 0);
    if (g >= 0) begin
      m_ldata = 32'(g) * 32'h0100_0000 + 32'(m_data[g]);
      m_pend[g] = 0;
      m_ptr = (g + 1) % NS;
    end
    any_drop = 0;
    for (int i = 0; i < NS; i++) begin
      drop_i = 0;
      if (trig[i] && sen[i] && en) begin
        if (!old_pend[i] || i == g) begin
          m_pend[i] = 1; m_data[i] = d[i];
        end else drop_i = 1;
      end
      if (dclr) m_cnt[i] = drop_i ? 1 : 0;
      else if (drop_i && m_cnt[i] < CMAX) m_cnt[i]++;
      any_drop |= drop_i;
    end
    if (any_drop) m_ov = 1;
    else if (dclr) m_ov = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    check("log_trigger", 32'(o_trig), 32'(m_trig));
    check("log_clear", 32'(o_clear), 32'(m_lclear));
    check("log_data", o_data, m_ldata);
    check("pending", 32'(o_pend), 32'(m_pend));
    check("overflow", 32'(o_ov), 32'(m_ov));
    for (int i = 0; i < NS; i++)
      check($sformatf("drop_cnt%0d", i), 32'(o_cnt[i*CW +: CW]), 32'(m_cnt[i]));
  endtask

  task automatic set_idle();
    en = 1; sen = '1; trig = '0; creq = 0; dclr = 0; rdy = 1;
    for (int i = 0; i < NS; i++) d[i] = 24'hABCDEF;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  typedef struct {
    logic [NS-1:0] trig;
    logic          creq;
    logic          exp_trig;
    int            exp_id;
    logic          exp_clear;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int ntrig, nclr, trig_at, clr_at;

    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b0, 1'b1, 0, 1'b0};
    tbl[2]  = '{4'b0100, 1'b0, 1'b0, 0, 1'b0};
    tbl[3]  = '{4'b0000, 1'b0, 1'b1, 2, 1'b0};
    tbl[4]  = '{4'b1000, 1'b0, 1'b0, 0, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 1'b1, 3, 1'b0};
    tbl[6]  = '{4'b1111, 1'b0, 1'b0, 0, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 1, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 1'b1, 2, 1'b0};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 3, 1'b0};
    tbl[11] = '{4'b1010, 1'b0, 1'b0, 0, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 1, 1'b0};
    tbl[13] = '{4'b0000, 1'b0, 1'b1, 3, 1'b0};
    tbl[14] = '{4'b0010, 1'b0, 1'b0, 0, 1'b0};
    tbl[15] = '{4'b0010, 1'b0, 1'b1, 1, 1'b0};
    tbl[16] = '{4'b0000, 1'b0, 1'b1, 1, 1'b0};
    tbl[17] = '{4'b0001, 1'b0, 1'b0, 0, 1'b0};
    tbl[18] = '{4'b0000, 1'b1, 1'b0, 0, 1'b0};
    tbl[19] = '{4'b0000, 1'b0, 1'b0, 0, 1'b1};
    tbl[20] = '{4'b0000, 1'b0, 1'b1, 0, 1'b0};
    tbl[21] = '{4'b0000, 1'b0, 1'b0, 0, 1'b0};

    set_idle();
    rst = 1;
    m_pend = '0;
    for (int i = 0; i < NS; i++) begin m_data[i] = '0; m_cnt[i] = 0; end
    repeat (2) step();
    rst = 0;
    check("reset_trigger", 32'(o_trig), 0);
    check("reset_pending", 32'(o_pend), 0);
    check("reset_data", o_data, 0);

    // Directed vectors: single events, round-robin order, grant+capture, clear collision.
    for (int r = 0; r < 22; r++) begin
      trig = tbl[r].trig;
      creq = tbl[r].creq;
      step();
      check($sformatf("tbl%0d_trigger", r), 32'(o_trig), 32'(tbl[r].exp_trig));
      check($sformatf("tbl%0d_clear", r), 32'(o_clear), 32'(tbl[r].exp_clear));
      if (tbl[r].exp_trig)
        check($sformatf("tbl%0d_data", r), o_data, 32'(tbl[r].exp_id) * 32'h0100_0000 + 32'hABCDEF);
    end
    set_idle();

    // Back-pressure into drops.
    do_reset();
    rdy = 0;
    trig = 4'b0010;
    repeat (3) step();
    trig = '0;
    step();
    check("bp_pending1", 32'(o_pend[1]), 1);
    check("bp_dropcnt1", 32'(o_cnt[1*CW +: CW]), 2);
    check("bp_overflow", 32'(o_ov), 1);
    rdy = 1;
    ntrig = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_trig) begin
        ntrig++;
        check("bp_id", 32'(o_data[31:24]), 1);
      end
    end
    check("bp_emit_count", 32'(ntrig), 1);

    // Clear request colliding with a grant, logger then not ready for 5 cycles.
    do_reset();
    trig = 4'b0001;
    step();
    trig = '0;
    creq = 1;
    step();
    creq = 0;
    check("cc_no_trigger", 32'(o_trig), 0);
    rdy = 0;
    ntrig = 0; nclr = 0; trig_at = -1; clr_at = -1;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) rdy = 1;
      step();
      if (o_clear) begin nclr++; clr_at = k; end
      if (o_trig) begin
        ntrig++; trig_at = k;
        check("cc_id", o_data, 32'h00ABCDEF);
      end
      check("cc_not_both", 32'(o_clear & o_trig), 0);
    end
    check("cc_clear_pulses", 32'(nclr), 1);
    check("cc_trigger_pulses", 32'(ntrig), 1);
    check("cc_order", 32'(trig_at > clr_at), 1);

    // Saturation and drop-counter clear.
    do_reset();
    rdy = 0;
    trig = 4'b1000;
    repeat (21) step();
    check("sat_dropcnt3", 32'(o_cnt[3*CW +: CW]), 15);
    trig = '0;
    dclr = 1;
    step();
    check("dclr_dropcnt3", 32'(o_cnt[3*CW +: CW]), 0);
    check("dclr_overflow", 32'(o_ov), 0);
    trig = 4'b1000;
    step();
    check("dclr_drop_dropcnt3", 32'(o_cnt[3*CW +: CW]), 1);
    check("dclr_drop_overflow", 32'(o_ov), 1);
    set_idle();

    // Reset in the middle of a burst.
    do_reset();
    trig = 4'b0100;
    step();
    trig = '0;
    repeat (2) step();
    rdy = 0;
    trig = 4'b1111;
    step();
    trig = '0;
    step();
    check("rst_pre_pending", 32'(o_pend), 32'hF);
    rst = 1;
    step();
    rst = 0;
    check("rst_trigger", 32'(o_trig), 0);
    check("rst_data", o_data, 0);
    check("rst_pending", 32'(o_pend), 0);
    check("rst_dropcnt", 32'(o_cnt), 0);
    check("rst_overflow", 32'(o_ov), 0);
    rdy = 1;
    ntrig = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      ntrig += int'(o_trig);
    end
    check("rst_no_stale", 32'(ntrig), 0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 399) == 0);
      en   = ($urandom_range(0, 7) != 0);
      sen  = 4'($urandom) | 4'($urandom);
      trig = 4'($urandom) & 4'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      creq = ($urandom_range(0, 15) == 0);
      dclr = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NS; i++) d[i] = 24'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
